// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the RV32I multi-cycle core: FSM states,
// base opcodes, instruction classes and the immediate-type encoding.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP
    } op_class_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Shared with the immediate generator
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction/data memory handshake between the controller (master) and
// the memory ports (slave).
interface multicycle_controller_if;

    logic imem_req;
    logic imem_ack;
    logic ir_write;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req, ir_write, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, ir_write, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );

endinterface

// File: rtl/multicycle_controller_opcode_classifier.sv
// Combinational RV32I base-opcode decode: immediate type, ALU operand-B
// select, instruction class and illegal flag.
module opcode_classifier
    import core_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] imm_type_o,
    output logic       alu_src_imm_o,
    output op_class_e  op_class_o,
    output logic       illegal_o
);

    always_comb begin
        imm_type_o    = IMM_NONE;
        alu_src_imm_o = 1'b0;
        op_class_o    = CLS_ALU;
        illegal_o     = 1'b0;
        case (opcode_i)
            OPC_OP_IMM: begin imm_type_o = IMM_I; alu_src_imm_o = 1'b1; end
            OPC_LOAD:   begin imm_type_o = IMM_I; alu_src_imm_o = 1'b1; op_class_o = CLS_LOAD; end
            OPC_JALR:   begin imm_type_o = IMM_I; alu_src_imm_o = 1'b1; op_class_o = CLS_JUMP; end
            OPC_STORE:  begin imm_type_o = IMM_S; alu_src_imm_o = 1'b1; op_class_o = CLS_STORE; end
            OPC_BRANCH: begin imm_type_o = IMM_B; op_class_o = CLS_BRANCH; end
            OPC_LUI,
            OPC_AUIPC:  begin imm_type_o = IMM_U; alu_src_imm_o = 1'b1; end
            OPC_JAL:    begin imm_type_o = IMM_J; alu_src_imm_o = 1'b1; op_class_o = CLS_JUMP; end
            OPC_OP:     ;
            default:    illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Define MULTICYCLE_CTRL_PERF_EN to build the cycle/instret counters.
module multicycle_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    multicycle_controller_if.master mem,
    input  logic                 branch_taken,
    output logic                 pc_write,
    output logic                 pc_sel_target,
    output logic                 reg_write,
    output logic                 alu_src_imm,
    output logic [2:0]           imm_type,
    output logic                 trap,
    output logic [2:0]           state_dbg,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt
);

    state_e     state_q;
    op_class_e  cls_q;
    logic [2:0] imm_type_q;
    logic       alu_src_imm_q, trap_q;
    logic       imem_req_q, dmem_req_q, dmem_we_q, reg_write_q;

    logic [2:0] dec_imm_type;
    logic       dec_alu_src, dec_illegal;
    op_class_e  dec_class;

    opcode_classifier u_classifier (
        .opcode_i      (opcode),
        .imm_type_o    (dec_imm_type),
        .alu_src_imm_o (dec_alu_src),
        .op_class_o    (dec_class),
        .illegal_o     (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            cls_q         <= CLS_ALU;
            imm_type_q    <= IMM_NONE;
            alu_src_imm_q <= 1'b0;
            trap_q        <= 1'b0;
            imem_req_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            reg_write_q   <= 1'b0;
        end else begin
            reg_write_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    imem_req_q <= 1'b1;
                    if (imem_req_q && mem.imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    imm_type_q    <= dec_imm_type;
                    alu_src_imm_q <= dec_alu_src;
                    cls_q         <= dec_class;
                    if (dec_illegal) begin
                        trap_q  <= 1'b1;
                        state_q <= ST_TRAP;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cls_q == CLS_BRANCH) begin
                        imem_req_q <= 1'b1;
                        state_q    <= ST_FETCH;
                    end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (cls_q == CLS_STORE);
                        state_q    <= ST_MEM;
                    end else begin
                        reg_write_q <= 1'b1;
                        state_q     <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem.dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (cls_q == CLS_STORE) begin
                            imem_req_q <= 1'b1;
                            state_q    <= ST_FETCH;
                        end else begin
                            reg_write_q <= 1'b1;
                            state_q     <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    imem_req_q <= 1'b1;
                    state_q    <= ST_FETCH;
                end
                ST_TRAP: ;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Ack-qualified pulses stay combinational so they land in the ack cycle.
    logic exec_branch, store_done;
    assign exec_branch = (state_q == ST_EXEC) && (cls_q == CLS_BRANCH);
    assign store_done  = dmem_req_q && dmem_we_q && mem.dmem_ack;

    assign mem.imem_req  = imem_req_q;
    assign mem.ir_write  = imem_req_q && mem.imem_ack;
    assign mem.dmem_req  = dmem_req_q;
    assign mem.dmem_we   = dmem_we_q;
    assign pc_write      = reg_write_q || exec_branch || store_done;
    assign pc_sel_target = (exec_branch && branch_taken) || (reg_write_q && cls_q == CLS_JUMP);
    assign reg_write     = reg_write_q;
    assign alu_src_imm   = alu_src_imm_q;
    assign imm_type      = imm_type_q;
    assign trap          = trap_q;
    assign state_dbg     = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != ST_TRAP) begin
            cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
            if (pc_write) instret_cnt_d = instret_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: random instruction stream with
// random memory wait states, plus trap and mid-access reset scenarios.
module tb_multicycle_controller;
    import core_ctrl_pkg::*;

    localparam int unsigned CW = 16;
`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = '0;
    logic          branch_taken = 1'b0;
    logic          pc_write, pc_sel_target, reg_write, alu_src_imm, trap;
    logic [2:0]    imm_type, state_dbg;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    multicycle_controller_if mem ();

    multicycle_controller #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem           (mem),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .pc_sel_target (pc_sel_target),
        .reg_write     (reg_write),
        .alu_src_imm   (alu_src_imm),
        .imm_type      (imm_type),
        .trap          (trap),
        .state_dbg     (state_dbg),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        bit          taken;
        int unsigned wait_n;
    } instr_t;

    typedef struct {
        bit          illegal;
        logic [2:0]  imm;
        bit          src;
        bit          we;
        bit          sel;
        bit          rw;
        int unsigned lat;
        int unsigned mcyc;
    } exp_t;

    logic [6:0] legal_opc [9] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                   7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

    instr_t prog[$];
    exp_t   sb[$];
    int unsigned n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic instr_t mk(input logic [6:0] opc, input bit taken, input int unsigned w);
        instr_t t;
        t.opc = opc; t.taken = taken; t.wait_n = w;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        return mk(legal_opc[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    endfunction

    // Reference: retire offset counted from the ir_write cycle.
    function automatic exp_t model(input instr_t i);
        exp_t e;
        bit is_load, is_store, is_branch, is_jump, wb;
        e = '{illegal: 1'b0, imm: 3'd0, src: 1'b0, we: 1'b0, sel: 1'b0, rw: 1'b0, lat: 0, mcyc: 0};
        is_load   = (i.opc == 7'b0000011);
        is_store  = (i.opc == 7'b0100011);
        is_branch = (i.opc == 7'b1100011);
        is_jump   = (i.opc == 7'b1101111) || (i.opc == 7'b1100111);
        case (i.opc)
            7'b0010011, 7'b0000011, 7'b1100111: begin e.imm = 3'd1; e.src = 1'b1; end
            7'b0100011:                         begin e.imm = 3'd2; e.src = 1'b1; end
            7'b1100011:                         e.imm = 3'd3;
            7'b0110111, 7'b0010111:             begin e.imm = 3'd4; e.src = 1'b1; end
            7'b1101111:                         begin e.imm = 3'd5; e.src = 1'b1; end
            7'b0110011:                         ;
            default:                            e.illegal = 1'b1;
        endcase
        wb     = !(is_branch || is_store);
        e.we   = is_store;
        e.rw   = wb;
        e.sel  = is_branch ? i.taken : is_jump;
        e.mcyc = (is_load || is_store) ? i.wait_n + 1 : 0;
        e.lat  = e.illegal ? 2 : 2 + e.mcyc + (wb ? 1 : 0);
        return e;
    endfunction

    // Memory/IR model: drives acks and loads the next opcode after each fetch.
    initial begin : driver
        instr_t cur;
        bit fetch_hit;
        int unsigned mem_cnt;
        fetch_hit = 1'b0;
        mem_cnt = 0;
        cur = mk(7'h00, 1'b0, 0);
        mem.imem_ack = 1'b0;
        mem.dmem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) fetch_hit = 1'b0;
            if (fetch_hit && prog.size() > 0) begin
                cur = prog.pop_front();
                opcode = cur.opc;
                branch_taken = cur.taken;
                mem_cnt = 0;
                sb.push_back(model(cur));
            end
            fetch_hit = 1'b0;
            if (mem.imem_req && prog.size() > 0) begin
                mem.imem_ack = ($urandom_range(0, 2) == 0);
                fetch_hit = mem.imem_ack;
            end else begin
                mem.imem_ack = ($urandom_range(0, 3) == 0) && !mem.imem_req;
            end
            if (mem.dmem_req) begin
                mem.dmem_ack = (mem_cnt == cur.wait_n);
                mem_cnt++;
            end else begin
                mem.dmem_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    int unsigned cyc = 0, ir_cyc = 0, m_cyc = 0, m_ret = 0, dreq_run = 0, fetch_at = 0;
    bit m_trap = 1'b0, trap_prev = 1'b0, pend_fetch = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (pend_fetch && cyc == fetch_at) begin
                check("state_after_retire", 32'(state_dbg), 32'd0);
                pend_fetch = 1'b0;
            end
            check("cycle_cnt", 32'(cycle_cnt), PERF ? 32'(CW'(m_cyc)) : 32'd0);
            check("instret_cnt", 32'(instret_cnt), PERF ? 32'(CW'(m_ret)) : 32'd0);
            if (mem.ir_write) begin
                ir_cyc = cyc;
                dreq_run = 0;
            end
            if (mem.dmem_req) begin
                dreq_run++;
                if (sb.size() > 0) check("dmem_we", 32'(mem.dmem_we), 32'(sb[0].we));
            end
            if (reg_write) check("reg_write_has_pc_write", 32'(pc_write), 32'd1);
            if (pc_write) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_retire: pc_write=1 with nothing outstanding (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("retire_latency", cyc - ir_cyc, e.lat);
                    check("pc_sel_target", 32'(pc_sel_target), 32'(e.sel));
                    check("reg_write", 32'(reg_write), 32'(e.rw));
                    check("imm_type", 32'(imm_type), 32'(e.imm));
                    check("alu_src_imm", 32'(alu_src_imm), 32'(e.src));
                    check("trap_at_retire", 32'(trap), 32'(e.illegal));
                    check("dmem_req_cycles", dreq_run, e.mcyc);
                    m_ret++;
                    pend_fetch = 1'b1;
                    fetch_at = cyc + 1;
                end
            end
            if (trap && !trap_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_trap: trap rose with nothing outstanding (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("trap_on_illegal", 32'(trap), 32'(e.illegal));
                    check("trap_latency", cyc - ir_cyc, e.lat);
                    check("trap_imm_type", 32'(imm_type), 32'(e.imm));
                    check("trap_alu_src_imm", 32'(alu_src_imm), 32'(e.src));
                    m_trap = 1'b1;
                end
            end
        end
        trap_prev = trap;
        if (rst) begin
            m_cyc = 0; m_ret = 0; m_trap = 1'b0; pend_fetch = 1'b0;
            sb.delete();
        end else if (!m_trap) begin
            m_cyc++;
        end
        cyc++;
    end

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while ((prog.size() > 0 || sb.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d queued, %0d outstanding after %0d cycles", prog.size(), sb.size(), n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
    endtask

    initial begin : main
        int unsigned n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_imem_req", 32'(mem.imem_req), 32'd0);
        check("rst_dmem_req", 32'(mem.dmem_req), 32'd0);
        check("rst_dmem_we", 32'(mem.dmem_we), 32'd0);
        check("rst_ir_write", 32'(mem.ir_write), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_imm_type", 32'(imm_type), 32'd0);
        check("rst_alu_src_imm", 32'(alu_src_imm), 32'd0);
        check("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        check("rst_instret_cnt", 32'(instret_cnt), 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        prog.push_back(mk(OPC_OP_IMM, 1'b0, 0));
        prog.push_back(mk(OPC_LOAD,   1'b0, 3));
        prog.push_back(mk(OPC_STORE,  1'b0, 1));
        prog.push_back(mk(OPC_BRANCH, 1'b1, 0));
        prog.push_back(mk(OPC_BRANCH, 1'b0, 0));
        prog.push_back(mk(OPC_JAL,    1'b0, 0));
        for (int i = 0; i < 60; i++) prog.push_back(rand_instr());
        drain(3000);

        prog.push_back(mk(7'b1111111, 1'b0, 0));
        n = 0;
        while (!trap && n < 60) begin @(negedge clk); n++; end
        check("trap_seen", 32'(trap), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("trap_held", 32'(trap), 32'd1);
            check("trap_no_imem_req", 32'(mem.imem_req), 32'd0);
            check("trap_state", 32'(state_dbg), 32'd5);
        end
        pulse_rst();
        @(negedge clk);
        check("post_trap_rst_trap", 32'(trap), 32'd0);
        check("post_trap_rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        check("post_trap_imem_req", 32'(mem.imem_req), 32'd1);

        prog.push_back(mk(OPC_LOAD, 1'b0, 1000));
        n = 0;
        while (!mem.dmem_req && n < 60) begin @(negedge clk); n++; end
        check("mem_req_seen", 32'(mem.dmem_req), 32'd1);
        pulse_rst();
        @(negedge clk);
        check("mid_mem_rst_dmem_req", 32'(mem.dmem_req), 32'd0);
        check("mid_mem_rst_state", 32'(state_dbg), 32'd0);
        check("mid_mem_rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        check("mid_mem_rst_instret_cnt", 32'(instret_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("mid_mem_rst_no_reg_write", 32'(reg_write), 32'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 12; i++) prog.push_back(rand_instr());
        drain(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
